instruction_prefetch_queue: RTL and testbench

Parametrised instruction fetch front end for the pipelined RV32 CPU. It replaces the single fetch register with a DEPTH-entry prefetch FIFO that keeps one instruction-memory request in flight, and accepts branch/jump redirects from execute. It snoops data-memory stores and invalidates any fetched or in-flight instruction that a store overwrites, so self-modifying code is refetched. The block sits between instruction memory and the decode stage of the control section.

---
 rtl/instruction_prefetch_queue.sv | 243 ++++++++++++++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_prefetch_queue
//
// Instruction fetch front end for the pipelined RV32 core. A DEPTH-entry FIFO
// of {pc, instruction} pairs sits between instruction memory and decode.
// At most one memory request is in flight. A FIFO slot is reserved for it when
// it is issued, so a completing request always has room.
//
// Execute can redirect the fetch stream for a taken branch or jump. Data-memory
// stores are snooped, and any queued or in-flight instruction they overwrite is
// discarded and fetched again.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   instruction_ready    fetch request valid, held until completion
//   instruction_address  word-aligned request address, stable while pending
//   instruction_wait     memory busy; a request completes when ready=1, wait=0
//   instruction          read data, valid in the completion cycle
//   out_valid/out_pc/out_instruction   head entry presented to decode
//   out_take             decode consumes the head this cycle
//   redirect/redirect_pc taken branch/jump: flush and refetch from target
//   store_write          store size (00 none, 01 byte, 10 half, 11 word)
//   store_address        store byte address
//   occupancy            number of valid FIFO entries
// -----------------------------------------------------------------------------
module instruction_prefetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      instruction_ready,
    output logic [XLEN-1:0]           instruction_address,
    input  logic                      instruction_wait,
    input  logic [XLEN-1:0]           instruction,
    output logic                      out_valid,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_instruction,
    input  logic                      out_take,
    input  logic                      redirect,
    input  logic [XLEN-1:0]           redirect_pc,
    input  logic [1:0]                store_write,
    input  logic [XLEN-1:0]           store_address,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // An instruction word at p occupies bytes [p, p+3]. The store occupies
    // [lo, hi]. Both ranges use XLEN+1 bits so a range near the top of the
    // address space does not wrap around to zero.
    function automatic logic overlaps(
        input logic [XLEN-1:0] p,
        input logic [XLEN:0]   lo,
        input logic [XLEN:0]   hi
    );
        logic [XLEN:0] base;
        base = {1'b0, p};
        return (lo <= base + (XLEN+1)'(3)) && (hi >= base);
    endfunction

    // ------------------------------------------------------------------ state
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_addr_q, req_addr_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             drop_q, drop_d;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];

    // ------------------------------------------------------- cycle events
    logic             complete;
    logic             take;
    logic             push;
    logic             issue;
    logic             pend_after;
    logic [PTR_W-1:0] head_ap;
    logic [CNT_W-1:0] cnt_ap;

    assign complete = pending_q & ~instruction_wait;
    assign take     = out_valid & out_take;
    // The head and count after this cycle's pop. Snooping only looks at
    // entries that survive the pop.
    assign head_ap  = head_q + PTR_W'(take);
    assign cnt_ap   = count_q - CNT_W'(take);

    // ------------------------------------------------------------ store snoop
    logic             store_active;
    logic [XLEN:0]    store_lo;
    logic [XLEN:0]    store_hi;
    logic [XLEN:0]    store_span;
    logic             entry_hit;
    logic [PTR_W-1:0] hit_pos;
    logic [PTR_W-1:0] hit_slot;
    logic [PTR_W-1:0] slot;
    logic             pend_hit;

    assign store_active = (store_write != 2'b00);
    assign store_lo     = {1'b0, store_address};
    assign store_hi     = store_lo + store_span;

    always_comb begin
        // NOTE: every signal written in always_comb gets a default value
        // first. If a path skips the assignment, a latch is inferred.
        store_span = '0;
        case (store_write)
            2'b10:   store_span = (XLEN+1)'(1);
            2'b11:   store_span = (XLEN+1)'(3);
            default: store_span = '0;
        endcase
    end

    // Find the oldest surviving entry that the store overlaps. The scan runs
    // from youngest to oldest, so the final match is the oldest one.
    always_comb begin
        entry_hit = 1'b0;
        hit_pos   = '0;
        hit_slot  = '0;
        slot      = '0;
        for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
            slot = head_ap + PTR_W'(j);
            if (store_active && (CNT_W'(j) < cnt_ap) &&
                overlaps(pc_mem[slot], store_lo, store_hi)) begin
                entry_hit = 1'b1;
                hit_pos   = PTR_W'(j);
                hit_slot  = slot;
            end
        end
    end

    // A request that is already being dropped is not snooped. Its data is
    // discarded anyway, and its address no longer belongs to the fetch stream.
    assign pend_hit = store_active & pending_q & ~drop_q &
                      overlaps(req_addr_q, store_lo, store_hi);

    // ------------------------------------------------------- next-state logic
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        drop_d     = drop_q;
        push       = 1'b0;

        // A completing request ends any pending drop.
        if (complete) begin
            drop_d = 1'b0;
        end

        if (redirect) begin
            // Flush everything. A request already on the bus cannot be
            // withdrawn, so it is marked for discard instead. A response that
            // completes in this cycle is discarded because push stays low.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            if (pending_q && !complete) begin
                drop_d = 1'b1;
            end
        end else if (entry_hit || pend_hit) begin
            // A store overwrote fetched code. Truncate the queue at the oldest
            // stale entry, or keep the whole queue if only the in-flight
            // request is stale. Then refetch from the first stale address.
            // Any in-flight request is younger than all queued entries, so it
            // is dropped in both cases.
            head_d = head_ap;
            if (entry_hit) begin
                tail_d     = head_ap + hit_pos;
                count_d    = CNT_W'(hit_pos);
                fetch_pc_d = pc_mem[hit_slot];
            end else begin
                count_d    = cnt_ap;
                fetch_pc_d = req_addr_q;
            end
            if (pending_q && !complete) begin
                drop_d = 1'b1;
            end
        end else begin
            push    = complete & ~drop_q;
            head_d  = head_ap;
            tail_d  = tail_q + PTR_W'(push);
            count_d = cnt_ap + CNT_W'(push);
            if (push) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
        end
    end

    // Issue a new request once the bus is free after this cycle and the queue
    // has room. The request takes the updated fetch_pc, so a zero-wait memory
    // receives a new request in every cycle.
    assign pend_after = pending_q & ~complete;
    assign issue      = ~pend_after & (count_d < CNT_W'(DEPTH));
    assign pending_d  = pend_after | issue;
    assign req_addr_d = issue ? fetch_pc_d : req_addr_q;

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before this clock edge.
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    // NOTE: the FIFO storage has no reset. Validity comes only from count_q,
    // and the outputs are gated by it, so an unwritten slot is never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= req_addr_q;
            instr_mem[tail_q] <= instruction;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign instruction_ready   = pending_q;
    assign instruction_address = req_addr_q;
    assign occupancy           = count_q;
    assign out_valid           = (count_q != '0);
    assign out_pc              = out_valid ? pc_mem[head_q]    : '0;
    assign out_instruction     = out_valid ? instr_mem[head_q] : '0;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_prefetch_queue
//
// Directed bench for instruction_prefetch_queue (XLEN=32, DEPTH=4, RESET_PC=0).
// The memory model returns the bitwise complement of the request address as
// the instruction, so pc and data are never equal. Inputs change 1 time unit
// after a rising edge. Outputs are checked at the same point, so each check
// sees the state registered at the preceding edge.
// -----------------------------------------------------------------------------
module tb_instruction_prefetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             instruction_ready;
    logic [XLEN-1:0]  instruction_address;
    logic             instruction_wait;
    logic [XLEN-1:0]  instruction;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_instruction;
    logic             out_take;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [1:0]       store_write;
    logic [XLEN-1:0]  store_address;
    logic [2:0]       occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign instruction = ~instruction_address;

    instruction_prefetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instruction_ready   (instruction_ready),
        .instruction_address (instruction_address),
        .instruction_wait    (instruction_wait),
        .instruction         (instruction),
        .out_valid           (out_valid),
        .out_pc              (out_pc),
        .out_instruction     (out_instruction),
        .out_take            (out_take),
        .redirect            (redirect),
        .redirect_pc         (redirect_pc),
        .store_write         (store_write),
        .store_address       (store_address),
        .occupancy           (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst              = 1'b0;
        instruction_wait = 1'b0;
        out_take         = 1'b0;
        redirect         = 1'b0;
        redirect_pc      = '0;
        store_write      = 2'b00;
        store_address    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".ready"},  32'(instruction_ready), 32'd0);
        check({tag, ".addr"},   instruction_address,    32'h0);
        check({tag, ".valid"},  32'(out_valid),         32'd0);
        check({tag, ".pc"},     out_pc,                 32'h0);
        check({tag, ".instr"},  out_instruction,        32'h0);
        check({tag, ".occ"},    32'(occupancy),         32'd0);
    endtask

    initial begin
        // ---------------------------------------------------------- reset
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_reset_state("reset");

        // ------------------------------ streaming: one instruction per cycle
        rst      = 1'b0;
        out_take = 1'b1;
        tick();
        check("stream.first_ready", 32'(instruction_ready), 32'd1);
        check("stream.first_addr",  instruction_address,    32'h0);
        check("stream.first_valid", 32'(out_valid),         32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stream.pc%0d", i),    out_pc,              32'(4 * i));
            check($sformatf("stream.instr%0d", i), out_instruction,     ~32'(4 * i));
            check($sformatf("stream.addr%0d", i),  instruction_address, 32'(4 * (i + 1)));
            check($sformatf("stream.ready%0d", i), 32'(instruction_ready), 32'd1);
            check($sformatf("stream.occ%0d", i),   32'(occupancy),      32'd1);
        end

        // ------------------------ fill to full, pop one, then the byte store
        do_reset();
        repeat (5) tick();
        check("full.ready", 32'(instruction_ready), 32'd0);
        check("full.occ",   32'(occupancy),         32'd4);
        check("full.pc",    out_pc,                 32'h0);
        tick();
        check("full.hold_ready", 32'(instruction_ready), 32'd0);
        out_take         = 1'b1;
        instruction_wait = 1'b1;
        tick();
        check("resume.ready", 32'(instruction_ready), 32'd1);
        check("resume.addr",  instruction_address,    32'h10);
        check("resume.occ",   32'(occupancy),         32'd3);
        check("resume.pc",    out_pc,                 32'h4);
        // The byte store hits the in-flight 0x10 only; the queue is kept.
        out_take      = 1'b0;
        store_write   = 2'b01;
        store_address = 32'h13;
        tick();
        check("bstore.ready", 32'(instruction_ready), 32'd1);
        check("bstore.addr",  instruction_address,    32'h10);
        check("bstore.occ",   32'(occupancy),         32'd3);
        check("bstore.pc",    out_pc,                 32'h4);
        store_write      = 2'b00;
        instruction_wait = 1'b0;
        tick();
        check("bstore.drop_occ",   32'(occupancy),         32'd3);
        check("bstore.refetch",    instruction_address,    32'h10);
        check("bstore.refetch_rd", 32'(instruction_ready), 32'd1);
        tick();
        check("bstore.full_occ",   32'(occupancy),         32'd4);
        check("bstore.full_ready", 32'(instruction_ready), 32'd0);
        out_take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bstore.drain_pc%0d", i),    out_pc,          32'(8 + 4 * i));
            check($sformatf("bstore.drain_instr%0d", i), out_instruction, ~32'(8 + 4 * i));
        end

        // ---------------------- redirect while a 3-wait request is pending
        do_reset();
        out_take = 1'b1;
        repeat (3) tick();
        check("redir.pre_addr", instruction_address, 32'h8);
        check("redir.pre_pc",   out_pc,              32'h4);
        instruction_wait = 1'b1;
        redirect         = 1'b1;
        redirect_pc      = 32'h103;
        tick();
        check("redir.flush_valid", 32'(out_valid),         32'd0);
        check("redir.flush_occ",   32'(occupancy),         32'd0);
        check("redir.hold_addr",   instruction_address,    32'h8);
        check("redir.hold_ready",  32'(instruction_ready), 32'd1);
        redirect = 1'b0;
        tick();
        tick();
        check("redir.hold_addr2",  instruction_address,    32'h8);
        check("redir.hold_ready2", 32'(instruction_ready), 32'd1);
        instruction_wait = 1'b0;
        tick();
        check("redir.new_addr",  instruction_address, 32'h100);
        check("redir.discarded", 32'(out_valid),      32'd0);
        tick();
        check("redir.out_valid", 32'(out_valid),      32'd1);
        check("redir.out_pc",    out_pc,              32'h100);
        check("redir.out_instr", out_instruction,     ~32'h100);
        check("redir.next_addr", instruction_address, 32'h104);

        // ------------------------- word store over queued code at 0x4..0xC
        do_reset();
        repeat (5) tick();
        check("wstore.pre_occ", 32'(occupancy), 32'd4);
        store_write   = 2'b11;
        store_address = 32'h6;
        tick();
        check("wstore.occ",   32'(occupancy),         32'd1);
        check("wstore.pc",    out_pc,                 32'h0);
        check("wstore.ready", 32'(instruction_ready), 32'd1);
        check("wstore.addr",  instruction_address,    32'h4);
        store_write = 2'b00;
        tick();
        check("wstore.refill_occ",  32'(occupancy),      32'd2);
        check("wstore.refill_addr", instruction_address, 32'h8);
        out_take = 1'b1;
        tick();
        check("wstore.second_pc",    out_pc,          32'h4);
        check("wstore.second_instr", out_instruction, ~32'h4);

        // ----------------------- address wrap, then reset in mid-request
        do_reset();
        out_take = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        check("wrap.addr0",  instruction_address, 32'hFFFF_FFF8);
        check("wrap.valid0", 32'(out_valid),      32'd0);
        redirect = 1'b0;
        tick();
        check("wrap.pc1",   out_pc,              32'hFFFF_FFF8);
        check("wrap.addr1", instruction_address, 32'hFFFF_FFFC);
        tick();
        check("wrap.pc2",   out_pc,              32'hFFFF_FFFC);
        check("wrap.addr2", instruction_address, 32'h0);
        tick();
        check("wrap.pc3",    out_pc,              32'h0);
        check("wrap.instr3", out_instruction,     32'hFFFF_FFFF);
        check("wrap.addr3",  instruction_address, 32'h4);
        instruction_wait = 1'b1;
        tick();
        check("midrst.pending", 32'(instruction_ready), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_state("midrst");
        rst              = 1'b0;
        instruction_wait = 1'b0;
        tick();
        check("midrst.restart_ready", 32'(instruction_ready), 32'd1);
        check("midrst.restart_addr",  instruction_address,    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
